memory_sdram_arbiter: RTL and testbench
=======================================

// Module: memory_sdram_arbiter
// PURPOSE
// - Upstream of the SDRAM controller: merges NUM_PORTS masters (N64 PI, USB DMA, CPU) into its single
//   request/busy/ack port. Round-robin grant; in-order tag FIFO routes each read ack to its issuing master.
// - Writes are posted (no ack). Reads return in issue order, one ack per accepted read.
// PARAMETERS
// - NUM_PORTS        3   number of upstream masters (2..4)
// - READ_FIFO_DEPTH  4   max outstanding reads, power of two (2..8)
// PORTS
// - i_clk            in   1          system clock
// - i_reset_n        in   1          asynchronous, active-low reset
// - i_request        in   NUM_PORTS  per-port request; held until accepted
// - i_write          in   NUM_PORTS  per-port direction (1 = write)
// - i_address        in   NUM_PORTS*25  per-port word address, port k at [k*25 +: 25]
// - i_data           in   NUM_PORTS*32  per-port write data, port k at [k*32 +: 32]
// - o_busy           out  NUM_PORTS  per-port stall; accept = i_request[k] && !o_busy[k]
// - o_ack            out  NUM_PORTS  one-cycle read-data-valid pulse, per port
// - o_data           out  32         read data, shared by all ports, valid with o_ack
// - o_ack_error      out  1          sticky: ack arrived with tag FIFO empty
// - o_mem_request    out  1          to controller request
// - o_mem_write      out  1          to controller write
// - o_mem_address    out  25         to controller address
// - o_mem_data       out  32         to controller write data
// - i_mem_busy       in   1          controller busy (combinational on o_mem_request)
// - i_mem_ack        in   1          controller read ack
// - i_mem_data       in   32         controller read data
// BEHAVIOUR
// - Reset (async, i_reset_n=0): o_ack=0, o_data=0, o_ack_error=0, rr pointer=0, tag FIFO empty.
// - Eligible port: i_request[k] && !(i_write[k]==0 && fifo_full). Grant is combinational: first eligible
//   port at or after rr pointer, wrapping NUM_PORTS-1 -> 0. No eligible port -> o_mem_request=0.
// - o_mem_request/write/address/data = granted port's signals, same cycle. No combinational path from
//   i_mem_busy into the grant.
// - o_busy[k] = i_request[k] && (!grant[k] || i_mem_busy || (!i_write[k] && fifo_full)).
// - Accept = o_mem_request && !i_mem_busy. On accept: rr pointer <= granted+1 (mod NUM_PORTS).
//   If read: push granted port id into the tag FIFO.
// - On i_mem_ack with FIFO non-empty: pop tag; next cycle o_ack[tag]=1 and o_data=i_mem_data
//   (latency 1, registered). Push and pop in the same cycle allowed, even when full: count unchanged.
// - On i_mem_ack with FIFO empty: discard, no o_ack, set o_ack_error (cleared only by reset).
// - Full FIFO: reads stall, writes still granted. Idle ports are skipped, never starving a requester;
//   worst-case wait is NUM_PORTS-1 accepts.
// - Reset mid-operation: outstanding tags are dropped. The controller is reset alongside; stray acks
//   after reset follow the empty-FIFO rule.
// CONFIGURATION
// - MEMORY_ARBITER_PORT0_PRIORITY_EN defined: port 0 wins whenever eligible; remaining ports round-robin
//   among themselves (a port-0 accept does not move the pointer).
// - Macro undefined: pure round-robin over all ports.
// STRUCTURE
// - memory_pkg: MEM_ADDR_W=25, MEM_DATA_W=32, port_id_t (2-bit), arbiter width constants.
// - Sub-module memory_arbiter_tag_fifo: sync FIFO of port_id_t, depth READ_FIFO_DEPTH, push/pop/full/empty,
//   simultaneous push+pop when full. Arbiter top holds grant logic, rr pointer, ack register.
// TESTING
// - Port1 read 0x0000100 alone, controller acks with 0xDEADBEEF 5 cycles later -> o_ack=3'b010 one
//   cycle after i_mem_ack, o_data=0xDEADBEEF.
// - Ports 0,1,2 all request reads continuously, i_mem_busy=0 -> accept order 0,1,2,0,1,2 and acks
//   routed in the same order.
// - 4 reads outstanding (FIFO full), port2 read + port0 write pending -> write accepted, read held
//   busy until the first ack frees a slot.
// - FIFO full, ack and new read accepted in the same cycle -> count stays 4, tag order preserved.
// - i_mem_ack with empty FIFO -> no o_ack, o_ack_error=1 until i_reset_n pulse.
// - PORT0_PRIORITY_EN, ports 0 and 2 requesting back-to-back -> port 0 served every cycle, port 2 only
//   when port 0 idle; reset asserted mid-burst -> outputs 0 immediately.

Source files
------------

// File: rtl/memory_pkg.sv
// -----------------------------------------------------------------------------
// memory_pkg
// Shared widths and types for the SDRAM-side memory path.
//   MEM_ADDR_W / MEM_DATA_W : controller word address and data widths
//   port_id_t               : identifies one upstream master (up to 4 ports)
//   wrap_port()             : (base + offset) wrapped into 0..num-1
// -----------------------------------------------------------------------------
package memory_pkg;

    localparam int MEM_ADDR_W    = 25;
    localparam int MEM_DATA_W    = 32;
    localparam int PORT_ID_W     = 2;
    localparam int ARB_MAX_PORTS = 4;

    typedef logic [PORT_ID_W-1:0] port_id_t;

    // Port counts need not be powers of two, so wrap with one compare
    // instead of a modulo; base and offset are always below num.
    function automatic port_id_t wrap_port(input int unsigned base,
                                           input int unsigned offset,
                                           input int unsigned num);
        int unsigned sum;
        sum = base + offset;
        return port_id_t'((sum >= num) ? sum - num : sum);
    endfunction

endpackage

// File: rtl/memory_arbiter_tag_fifo.sv
// -----------------------------------------------------------------------------
// memory_arbiter_tag_fifo
// Synchronous FIFO of port ids, one entry per outstanding read. Remembers
// which master issued each read so in-order acks can be routed back.
// Push and pop in the same cycle are honoured even when full.
//   i_clk, i_reset_n       : clock, asynchronous active-low reset
//   i_push, i_push_data    : enqueue a port id
//   i_pop, o_pop_data      : dequeue; o_pop_data is the current head
//   o_full, o_empty        : occupancy flags
// -----------------------------------------------------------------------------
module memory_arbiter_tag_fifo
    import memory_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     i_clk,
    input  logic     i_reset_n,
    input  logic     i_push,
    input  port_id_t i_push_data,
    input  logic     i_pop,
    output port_id_t o_pop_data,
    output logic     o_full,
    output logic     o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    port_id_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign o_full     = (count == FULL_COUNT);
    assign o_empty    = (count == '0);
    assign o_pop_data = mem[rd_ptr];
    assign do_pop     = i_pop && !o_empty;
    // A pop in the same cycle frees the slot this push lands in.
    assign do_push    = i_push && (!o_full || do_pop);

    // NOTE: storage has no reset; count and pointers alone define validity,
    // and leaving the array unreset lets it map onto plain registers/LUT RAM.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= i_push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/memory_sdram_arbiter.sv
// -----------------------------------------------------------------------------
// memory_sdram_arbiter
// Merges NUM_PORTS masters onto the single SDRAM controller port. Grant is
// combinational round-robin over eligible ports; writes are posted, reads are
// tagged in a FIFO so each in-order controller ack is routed to its issuer.
// Optional build macro: MEMORY_ARBITER_PORT0_PRIORITY_EN -- port 0 wins
// whenever eligible, the other ports round-robin among themselves.
//   i_clk, i_reset_n                      : clock, async active-low reset
//   i_request/i_write/i_address/i_data    : per-port request bundle (packed)
//   o_busy                                : per-port stall
//   o_ack, o_data                         : registered read return
//   o_ack_error                           : sticky, ack with no outstanding read
//   o_mem_request/write/address/data      : to the controller
//   i_mem_busy, i_mem_ack, i_mem_data     : from the controller
// -----------------------------------------------------------------------------
module memory_sdram_arbiter
    import memory_pkg::*;
#(
    parameter int NUM_PORTS       = 3,
    parameter int READ_FIFO_DEPTH = 4
) (
    input  logic                            i_clk,
    input  logic                            i_reset_n,
    input  logic [NUM_PORTS-1:0]            i_request,
    input  logic [NUM_PORTS-1:0]            i_write,
    input  logic [NUM_PORTS*MEM_ADDR_W-1:0] i_address,
    input  logic [NUM_PORTS*MEM_DATA_W-1:0] i_data,
    output logic [NUM_PORTS-1:0]            o_busy,
    output logic [NUM_PORTS-1:0]            o_ack,
    output logic [MEM_DATA_W-1:0]           o_data,
    output logic                            o_ack_error,
    output logic                            o_mem_request,
    output logic                            o_mem_write,
    output logic [MEM_ADDR_W-1:0]           o_mem_address,
    output logic [MEM_DATA_W-1:0]           o_mem_data,
    input  logic                            i_mem_busy,
    input  logic                            i_mem_ack,
    input  logic [MEM_DATA_W-1:0]           i_mem_data
);

    port_id_t             rr_ptr;
    port_id_t             grant_idx;
    logic                 grant_valid;
    logic [NUM_PORTS-1:0] grant_vec;
    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] rr_eligible;
    logic                 read_blocked;
    logic                 accept;
    logic                 rr_advance;
    logic [NUM_PORTS-1:0] ack_next;
    logic                 tag_full;
    logic                 tag_empty;
    port_id_t             tag_head;

    // An ack this cycle pops a tag, so a read may take the freed slot in the
    // same cycle. i_mem_busy never feeds the grant.
    assign read_blocked = tag_full && !i_mem_ack;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        eligible    = '0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            eligible[k] = i_request[k] && (i_write[k] || !read_blocked);
        end
        rr_eligible = eligible;
`ifdef MEMORY_ARBITER_PORT0_PRIORITY_EN
        rr_eligible[0] = 1'b0;
`endif
        // First eligible port at or after the pointer, wrapping.
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!grant_valid && rr_eligible[wrap_port(rr_ptr, i, NUM_PORTS)]) begin
                grant_valid = 1'b1;
                grant_idx   = wrap_port(rr_ptr, i, NUM_PORTS);
            end
        end
`ifdef MEMORY_ARBITER_PORT0_PRIORITY_EN
        if (eligible[0]) begin
            grant_valid = 1'b1;
            grant_idx   = '0;
        end
`endif
    end

    always_comb begin
        grant_vec = '0;
        o_busy    = '0;
        ack_next  = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            grant_vec[k] = grant_valid && (grant_idx == port_id_t'(k));
            o_busy[k]    = i_request[k] &&
                           (!grant_vec[k] || i_mem_busy || (!i_write[k] && read_blocked));
            ack_next[k]  = i_mem_ack && !tag_empty && (tag_head == port_id_t'(k));
        end
    end

    assign o_mem_request = grant_valid;
    assign o_mem_write   = grant_valid && i_write[grant_idx];
    assign o_mem_address = grant_valid ? i_address[grant_idx*MEM_ADDR_W +: MEM_ADDR_W] : '0;
    assign o_mem_data    = grant_valid ? i_data[grant_idx*MEM_DATA_W +: MEM_DATA_W] : '0;

    assign accept = grant_valid && !i_mem_busy;
`ifdef MEMORY_ARBITER_PORT0_PRIORITY_EN
    // Port 0 sits outside the rotation; its accepts leave the pointer alone.
    assign rr_advance = accept && (grant_idx != '0);
`else
    assign rr_advance = accept;
`endif

    memory_arbiter_tag_fifo #(
        .DEPTH (READ_FIFO_DEPTH)
    ) u_tag_fifo (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_push      (accept && !o_mem_write),
        .i_push_data (grant_idx),
        .i_pop       (i_mem_ack),
        .o_pop_data  (tag_head),
        .o_full      (tag_full),
        .o_empty     (tag_empty)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rr_ptr      <= '0;
            o_ack       <= '0;
            o_data      <= '0;
            o_ack_error <= 1'b0;
        end else begin
            if (rr_advance) begin
                rr_ptr <= wrap_port(grant_idx, 1, NUM_PORTS);
            end
            o_ack <= ack_next;
            if (i_mem_ack && !tag_empty) begin
                o_data <= i_mem_data;
            end
            // An ack with nothing outstanding is dropped and flagged until reset.
            if (i_mem_ack && tag_empty) begin
                o_ack_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_memory_sdram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_memory_sdram_arbiter
// Directed bench: a table of grant vectors, then hand-written sequences for
// read routing, FIFO-full stalls, simultaneous push/pop, stray acks and
// reset mid-operation. Expected orders follow the build macro in use.
// -----------------------------------------------------------------------------
module tb_memory_sdram_arbiter;

    localparam int NP = 3;

    logic             i_clk = 1'b0;
    logic             i_reset_n;
    logic [NP-1:0]    i_request;
    logic [NP-1:0]    i_write;
    logic [NP*25-1:0] i_address;
    logic [NP*32-1:0] i_data;
    logic [NP-1:0]    o_busy;
    logic [NP-1:0]    o_ack;
    logic [31:0]      o_data;
    logic             o_ack_error;
    logic             o_mem_request;
    logic             o_mem_write;
    logic [24:0]      o_mem_address;
    logic [31:0]      o_mem_data;
    logic             i_mem_busy;
    logic             i_mem_ack;
    logic [31:0]      i_mem_data;

    logic [24:0] port_addr [NP];
    logic [31:0] port_data [NP];

    int errors = 0;
    int checks = 0;

    always #5 i_clk = ~i_clk;

    initial begin
        port_addr[0] = 25'h0000010;
        port_addr[1] = 25'h0000100;
        port_addr[2] = 25'h0001000;
        port_data[0] = 32'hA000_0000;
        port_data[1] = 32'hA000_0001;
        port_data[2] = 32'hA000_0002;
    end

    assign i_address = {port_addr[2], port_addr[1], port_addr[0]};
    assign i_data    = {port_data[2], port_data[1], port_data[0]};

    memory_sdram_arbiter #(
        .NUM_PORTS       (NP),
        .READ_FIFO_DEPTH (4)
    ) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_request     (i_request),
        .i_write       (i_write),
        .i_address     (i_address),
        .i_data        (i_data),
        .o_busy        (o_busy),
        .o_ack         (o_ack),
        .o_data        (o_data),
        .o_ack_error   (o_ack_error),
        .o_mem_request (o_mem_request),
        .o_mem_write   (o_mem_write),
        .o_mem_address (o_mem_address),
        .o_mem_data    (o_mem_data),
        .i_mem_busy    (i_mem_busy),
        .i_mem_ack     (i_mem_ack),
        .i_mem_data    (i_mem_data)
    );

    typedef struct {
        logic [NP-1:0] req;
        logic [NP-1:0] wr;
        logic          mb;
        int            exp_port;   // -1: no grant expected
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] actual,
                         input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_reset_n  = 1'b0;
        i_request  = '0;
        i_write    = '0;
        i_mem_busy = 1'b0;
        i_mem_ack  = 1'b0;
        i_mem_data = '0;
        @(negedge i_clk);
        i_reset_n = 1'b1;
        next_cycle();
    endtask

    initial begin
        int            rd_order [4];
        logic [NP-1:0] ack_order [4];
        logic [NP-1:0] gmask;
        int            p;

        // Pure writes, so the tag FIFO stays empty; pointer evolves per row.
        vecs[0] = '{3'b000, 3'b111, 1'b0, -1};
        vecs[1] = '{3'b111, 3'b111, 1'b1,  0};
        vecs[2] = '{3'b111, 3'b111, 1'b0,  0};
`ifdef MEMORY_ARBITER_PORT0_PRIORITY_EN
        vecs[3] = '{3'b101, 3'b111, 1'b0,  0};
        vecs[4] = '{3'b110, 3'b111, 1'b0,  1};
        vecs[5] = '{3'b011, 3'b111, 1'b0,  0};
        vecs[6] = '{3'b111, 3'b111, 1'b0,  0};
        vecs[7] = '{3'b111, 3'b111, 1'b0,  0};
        rd_order  = '{0, 0, 0, 0};
        ack_order = '{3'b001, 3'b001, 3'b001, 3'b100};
`else
        vecs[3] = '{3'b101, 3'b111, 1'b0,  2};
        vecs[4] = '{3'b110, 3'b111, 1'b0,  1};
        vecs[5] = '{3'b011, 3'b111, 1'b0,  0};
        vecs[6] = '{3'b111, 3'b111, 1'b0,  1};
        vecs[7] = '{3'b111, 3'b111, 1'b0,  2};
        rd_order  = '{0, 1, 2, 0};
        ack_order = '{3'b010, 3'b100, 3'b001, 3'b100};
`endif
        vecs[8] = '{3'b000, 3'b000, 1'b0, -1};

        // Reset state
        i_reset_n  = 1'b0;
        i_request  = '0;
        i_write    = '0;
        i_mem_busy = 1'b0;
        i_mem_ack  = 1'b0;
        i_mem_data = '0;
        #12;
        check("reset o_ack", o_ack, 3'b000);
        check("reset o_data", o_data, 32'h0);
        check("reset o_ack_error", o_ack_error, 1'b0);
        check("reset o_mem_request", o_mem_request, 1'b0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        next_cycle();

        // Grant table
        for (int i = 0; i < 9; i++) begin
            i_request  = vecs[i].req;
            i_write    = vecs[i].wr;
            i_mem_busy = vecs[i].mb;
            @(negedge i_clk);
            p     = vecs[i].exp_port;
            gmask = (p >= 0) ? (3'b001 << p) : 3'b000;
            check($sformatf("v%0d mem_request", i), o_mem_request, p >= 0);
            if (p >= 0) begin
                check($sformatf("v%0d mem_write", i), o_mem_write, vecs[i].wr[p]);
                check($sformatf("v%0d mem_address", i), o_mem_address, port_addr[p]);
                check($sformatf("v%0d mem_data", i), o_mem_data, port_data[p]);
            end
            check($sformatf("v%0d busy", i), o_busy,
                  vecs[i].mb ? vecs[i].req : (vecs[i].req & ~gmask));
            next_cycle();
        end

        // Single read from port 1, ack five cycles later
        do_reset();
        i_request = 3'b010;
        i_write   = 3'b000;
        @(negedge i_clk);
        check("p1 read mem_request", o_mem_request, 1'b1);
        check("p1 read mem_write", o_mem_write, 1'b0);
        check("p1 read mem_address", o_mem_address, 25'h0000100);
        check("p1 read busy", o_busy, 3'b000);
        next_cycle();
        i_request = '0;
        repeat (4) next_cycle();
        i_mem_ack  = 1'b1;
        i_mem_data = 32'hDEAD_BEEF;
        @(negedge i_clk);
        check("p1 ack not early", o_ack, 3'b000);
        next_cycle();
        i_mem_ack = 1'b0;
        @(negedge i_clk);
        check("p1 o_ack", o_ack, 3'b010);
        check("p1 o_data", o_data, 32'hDEAD_BEEF);
        next_cycle();
        @(negedge i_clk);
        check("p1 o_ack pulse", o_ack, 3'b000);
        check("p1 no error", o_ack_error, 1'b0);

        // All ports reading until the tag FIFO fills
        do_reset();
        i_request = 3'b111;
        i_write   = 3'b000;
        for (int j = 0; j < 4; j++) begin
            @(negedge i_clk);
            check($sformatf("rd%0d mem_request", j), o_mem_request, 1'b1);
            check($sformatf("rd%0d grant addr", j), o_mem_address, port_addr[rd_order[j]]);
            next_cycle();
        end
        @(negedge i_clk);
        check("full mem_request", o_mem_request, 1'b0);
        check("full busy", o_busy, 3'b111);
        next_cycle();

        // Full: port 0 write passes, port 2 read held
        i_request = 3'b101;
        i_write   = 3'b001;
        @(negedge i_clk);
        check("full write mem_request", o_mem_request, 1'b1);
        check("full write mem_write", o_mem_write, 1'b1);
        check("full write addr", o_mem_address, port_addr[0]);
        check("full write busy", o_busy, 3'b100);
        next_cycle();
        i_request = 3'b100;
        i_write   = 3'b000;
        @(negedge i_clk);
        check("full read held", o_mem_request, 1'b0);
        check("full read busy", o_busy, 3'b100);
        #2;
        // Ack arrives: the freed slot takes the port 2 read in the same cycle
        i_mem_ack  = 1'b1;
        i_mem_data = 32'h1111_1111;
        #1;
        check("pushpop mem_request", o_mem_request, 1'b1);
        check("pushpop addr", o_mem_address, port_addr[2]);
        check("pushpop busy", o_busy, 3'b000);
        next_cycle();
        i_mem_ack = 1'b0;
        @(negedge i_clk);
        check("pushpop o_ack", o_ack, 3'b001);
        check("pushpop o_data", o_data, 32'h1111_1111);
        check("still full mem_request", o_mem_request, 1'b0);
        check("still full busy", o_busy, 3'b100);
        next_cycle();
        i_request = '0;

        // Drain: tags come back in issue order
        for (int j = 0; j < 4; j++) begin
            i_mem_ack  = 1'b1;
            i_mem_data = 32'h2000_0000 + j;
            next_cycle();
            i_mem_ack = 1'b0;
            @(negedge i_clk);
            check($sformatf("drain%0d o_ack", j), o_ack, ack_order[j]);
            check($sformatf("drain%0d o_data", j), o_data, 32'h2000_0000 + j);
            next_cycle();
        end

        // Stray ack with empty FIFO
        i_mem_ack  = 1'b1;
        i_mem_data = 32'h3333_3333;
        next_cycle();
        i_mem_ack = 1'b0;
        @(negedge i_clk);
        check("stray o_ack", o_ack, 3'b000);
        check("stray o_ack_error", o_ack_error, 1'b1);
        repeat (3) next_cycle();
        check("stray error sticky", o_ack_error, 1'b1);

        // Reset while an ack is being presented
        i_request = 3'b001;
        i_write   = 3'b000;
        next_cycle();
        i_request  = '0;
        i_mem_ack  = 1'b1;
        i_mem_data = 32'h5555_AAAA;
        next_cycle();
        i_mem_ack = 1'b0;
        @(negedge i_clk);
        check("pre-reset o_ack", o_ack, 3'b001);
        check("pre-reset o_data", o_data, 32'h5555_AAAA);
        #1;
        i_reset_n = 1'b0;
        #1;
        check("async reset o_ack", o_ack, 3'b000);
        check("async reset o_data", o_data, 32'h0);
        check("async reset o_ack_error", o_ack_error, 1'b0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        next_cycle();

`ifdef MEMORY_ARBITER_PORT0_PRIORITY_EN
        // Ports 0 and 2 writing back-to-back: port 0 every cycle
        i_request = 3'b101;
        i_write   = 3'b101;
        for (int j = 0; j < 3; j++) begin
            @(negedge i_clk);
            check($sformatf("pri%0d addr", j), o_mem_address, port_addr[0]);
            check($sformatf("pri%0d busy", j), o_busy, 3'b100);
            next_cycle();
        end
        i_request = 3'b100;
        @(negedge i_clk);
        check("pri p2 addr", o_mem_address, port_addr[2]);
        check("pri p2 busy", o_busy, 3'b000);
        next_cycle();
        i_request = '0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
